// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - in-flight writeback tracker with operand forwarding and load-use stall
//
// Tracks DEPTH in-flight register writebacks (slot 0 youngest, slot DEPTH-1
// oldest) and, for each of NUM_SRC source operands, forwards the youngest
// matching ready result or flags a load-use stall.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   adv               shift all slots one place older, load slot 0 from ex_*
//   flush             invalidate all slots (wins over adv/ex_*/ld_valid)
//   ex_valid, ex_regWrite, ex_memRead, ex_rd, ex_res
//                     EX-stage instruction entering slot 0 on adv
//   ld_valid, ld_data load data return for the oldest pending load
//   src_r             NUM_SRC x 5-bit source register numbers (flattened)
//   fwd_en, fwd_data  per-source forward enable / data (flattened)
//   stall             some source hits a not-yet-ready slot
//   err               sticky protocol error (stray load return, unready retire)
//   stall_cnt         saturating stall-cycle counter, present only when
//                     FWD_STALL_CNT_EN is defined
module forwarding_scoreboard #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        adv,
    input  logic                        flush,
    input  logic                        ex_valid,
    input  logic                        ex_regWrite,
    input  logic                        ex_memRead,
    input  logic [4:0]                  ex_rd,
    input  logic [DATA_W-1:0]           ex_res,
    input  logic                        ld_valid,
    input  logic [DATA_W-1:0]           ld_data,
    input  logic [NUM_SRC*5-1:0]        src_r,
    output logic [NUM_SRC-1:0]          fwd_en,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic                        stall,
`ifdef FWD_STALL_CNT_EN
    output logic [15:0]                 stall_cnt,
`endif
    output logic                        err
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             ready_q, ready_d;
    logic [DEPTH-1:0][4:0]        rd_q, rd_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic                         err_q, err_d;

    logic       ld_hit;
    logic [3:0] ld_idx;
    logic       retire_unready;

    // Oldest valid not-ready slot: scanning upward, the last hit is the oldest.
    always_comb begin
        ld_hit = 1'b0;
        ld_idx = 4'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[k] && !ready_q[k]) begin
                ld_hit = 1'b1;
                ld_idx = 4'(k);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        rd_d    = rd_q;
        data_d  = data_q;

        if (adv) begin
            for (int j = 1; j < DEPTH; j++) begin
                valid_d[j] = valid_q[j-1];
                ready_d[j] = ready_q[j-1];
                rd_d[j]    = rd_q[j-1];
                data_d[j]  = data_q[j-1];
            end
            valid_d[0] = ex_valid && ex_regWrite && (ex_rd != 5'd0);
            ready_d[0] = !ex_memRead;
            rd_d[0]    = ex_rd;
            data_d[0]  = ex_memRead ? '0 : ex_res;
        end

        // Load completion lands on the entry's post-shift position; an entry
        // retiring out of DEPTH-1 simply has no position to land on.
        if (ld_valid && ld_hit) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((adv && j > 0 && ld_idx == 4'(j-1)) || (!adv && ld_idx == 4'(j))) begin
                    ready_d[j] = 1'b1;
                    data_d[j]  = ld_data;
                end
            end
        end

        if (flush) begin
            valid_d = '0;
        end
    end

    assign retire_unready = adv && valid_q[DEPTH-1] && !ready_q[DEPTH-1]
                            && !(ld_valid && ld_hit && ld_idx == 4'(DEPTH-1));
    assign err_d = err_q || (!flush && (retire_unready || (ld_valid && !ld_hit)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            ready_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Scan oldest to youngest so the youngest matching slot overrides.
    always_comb begin
        fwd_en   = '0;
        fwd_data = '0;
        stall    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic             hit;
            logic             rdy;
            logic [DATA_W-1:0] dat;
            hit = 1'b0;
            rdy = 1'b0;
            dat = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (valid_q[k] && src_r[5*i +: 5] != 5'd0 && rd_q[k] == src_r[5*i +: 5]) begin
                    hit = 1'b1;
                    rdy = ready_q[k];
                    dat = data_q[k];
                end
            end
            if (hit && rdy) begin
                fwd_en[i]                 = 1'b1;
                fwd_data[DATA_W*i +: DATA_W] = dat;
            end
            if (hit && !rdy) begin
                stall = 1'b1;
            end
        end
    end

    assign err = err_q;

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb/tb_forwarding_scoreboard.sv - directed self-checking bench for forwarding_scoreboard
module tb_forwarding_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        adv;
    logic        flush;
    logic        ex_valid;
    logic        ex_regWrite;
    logic        ex_memRead;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [9:0]  src_r;
    logic [1:0]  fwd_en;
    logic [63:0] fwd_data;
    logic        stall;
    logic        err;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    forwarding_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adv         (adv),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_regWrite (ex_regWrite),
        .ex_memRead  (ex_memRead),
        .ex_rd       (ex_rd),
        .ex_res      (ex_res),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .src_r       (src_r),
        .fwd_en      (fwd_en),
        .fwd_data    (fwd_data),
        .stall       (stall),
`ifdef FWD_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .err         (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle; inputs return to idle afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        adv         = 1'b0;
        flush       = 1'b0;
        ex_valid    = 1'b0;
        ex_regWrite = 1'b0;
        ex_memRead  = 1'b0;
        ex_rd       = 5'd0;
        ex_res      = 32'd0;
        ld_valid    = 1'b0;
        ld_data     = 32'd0;
    endtask

    task automatic set_ex(input logic mem, input logic [4:0] rd, input logic [31:0] res);
        adv         = 1'b1;
        ex_valid    = 1'b1;
        ex_regWrite = 1'b1;
        ex_memRead  = mem;
        ex_rd       = rd;
        ex_res      = res;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b1;
        adv   = 1'b1;
        ld_valid = 1'b1;
        @(posedge clk);
        #1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        adv = 0; flush = 0; ex_valid = 0; ex_regWrite = 0; ex_memRead = 0;
        ex_rd = 0; ex_res = 0; ld_valid = 0; ld_data = 0;
        src_r = {5'd5, 5'd5};
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_fwd_en", 64'(fwd_en), 64'h0);
        chk("rst_fwd_data", fwd_data, 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_err", 64'(err), 64'h0);

        // ALU forward, latency 1
        src_r = {5'd0, 5'd5};
        set_ex(1'b0, 5'd5, 32'h1234);
        tick();
        chk("alu_fwd_en", 64'(fwd_en), 64'h1);
        chk("alu_fwd_data", fwd_data, 64'h0000_0000_0000_1234);
        chk("alu_stall", 64'(stall), 64'h0);

        // youngest wins
        set_ex(1'b0, 5'd5, 32'hA);
        tick();
        set_ex(1'b0, 5'd5, 32'hB);
        tick();
        src_r = {5'd5, 5'd5};
        #1;
        chk("young_fwd_en", 64'(fwd_en), 64'h3);
        chk("young_fwd_data", fwd_data, 64'h0000_000B_0000_000B);

        // adv=0 ignores ex_*
        src_r = {5'd10, 5'd0};
        ex_valid = 1; ex_regWrite = 1; ex_rd = 5'd10; ex_res = 32'h77;
        tick();
        chk("noadv_ignored", 64'(fwd_en), 64'h0);

        flush = 1'b1;
        tick();
        src_r = {5'd5, 5'd5};
        #1;
        chk("flush_clears", 64'(fwd_en), 64'h0);

        // load-use stall then load return
        src_r = {5'd7, 5'd0};
        set_ex(1'b1, 5'd7, 32'hFFFF);
        tick();
        chk("lu_stall", 64'(stall), 64'h1);
        chk("lu_fwd_en", 64'(fwd_en), 64'h0);
        chk("lu_fwd_data", fwd_data, 64'h0);
        ld_valid = 1'b1; ld_data = 32'hBEEF;
        tick();
        chk("ld_fwd_en", 64'(fwd_en), 64'h2);
        chk("ld_fwd_data", fwd_data, 64'h0000_BEEF_0000_0000);
        chk("ld_stall", 64'(stall), 64'h0);
        chk("ld_no_err", 64'(err), 64'h0);

        // stray load return is sticky error
        ld_valid = 1'b1; ld_data = 32'h1;
        tick();
        chk("stray_ld_err", 64'(err), 64'h1);
        flush = 1'b1;
        tick();
        tick();
        chk("err_sticky", 64'(err), 64'h1);
        do_reset();
        chk("err_cleared", 64'(err), 64'h0);

        // unready load retiring
        src_r = {5'd0, 5'd9};
        set_ex(1'b1, 5'd9, 32'h0);
        tick();
        adv = 1'b1;
        tick();
        adv = 1'b1;
        tick();
        chk("oldest_stall", 64'(stall), 64'h1);
        chk("pre_retire_err", 64'(err), 64'h0);
        adv = 1'b1;
        tick();
        chk("retire_err", 64'(err), 64'h1);
        chk("retired_gone", 64'(stall), 64'h0);

        // load completing as it retires: no error
        do_reset();
        set_ex(1'b1, 5'd9, 32'h0);
        tick();
        adv = 1'b1;
        tick();
        adv = 1'b1;
        tick();
        adv = 1'b1; ld_valid = 1'b1; ld_data = 32'h42;
        tick();
        chk("retire_ld_no_err", 64'(err), 64'h0);

        // load completion applied at post-shift position
        src_r = {5'd3, 5'd4};
        set_ex(1'b1, 5'd3, 32'h0);
        tick();
        set_ex(1'b0, 5'd4, 32'h66);
        ld_valid = 1'b1; ld_data = 32'h55;
        tick();
        chk("shift_ld_en", 64'(fwd_en), 64'h3);
        chk("shift_ld_data", fwd_data, 64'h0000_0055_0000_0066);
        chk("shift_ld_stall", 64'(stall), 64'h0);

        // flush overrides adv, ex_* and ld_valid; err untouched
        do_reset();
        src_r = {5'd8, 5'd6};
        set_ex(1'b1, 5'd8, 32'h0);
        tick();
        chk("pend_stall", 64'(stall), 64'h1);
        set_ex(1'b0, 5'd6, 32'h99);
        ld_valid = 1'b1; ld_data = 32'h11;
        flush = 1'b1;
        tick();
        chk("flush_all_en", 64'(fwd_en), 64'h0);
        chk("flush_all_stall", 64'(stall), 64'h0);
        chk("flush_err_kept", 64'(err), 64'h0);

        // r0 never forwards
        src_r = {5'd0, 5'd0};
        set_ex(1'b0, 5'd0, 32'hDEAD);
        tick();
        chk("r0_no_fwd", 64'(fwd_en), 64'h0);
        chk("r0_no_data", fwd_data, 64'h0);

        // regWrite=0 not tracked
        src_r = {5'd12, 5'd0};
        set_ex(1'b0, 5'd12, 32'h5);
        ex_regWrite = 1'b0;
        tick();
        chk("nowrite_no_fwd", 64'(fwd_en), 64'h0);

`ifdef FWD_STALL_CNT_EN
        do_reset();
        chk("cnt_rst", 64'(stall_cnt), 64'h0);
        src_r = {5'd7, 5'd0};
        set_ex(1'b1, 5'd7, 32'h0);
        tick();
        tick();
        tick();
        tick();
        chk("cnt_3", 64'(stall_cnt), 64'd3);
        for (int n = 0; n < 65531; n++) tick();
        chk("cnt_fffe", 64'(stall_cnt), 64'hFFFE);
        for (int n = 0; n < 5; n++) tick();
        chk("cnt_sat", 64'(stall_cnt), 64'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
